// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Request-level front end for the 1024x12 memory block. It accepts single-word
// read and write requests over a valid/ready handshake. Each request becomes
// the memory's native bus sequence: a read takes one bus cycle, and a write
// takes three (address latch, low-half commit, high-half commit).
//
// Optional feature: define MEM_SEQ_WRITE_VERIFY_EN to read back every write one
// cycle after its high-half commit. A mismatch sets the sticky verify_err flag.
// Without the macro there is no verify state and verify_err is tied low.
module mem_access_sequencer (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [9:0]  req_addr,
    input  logic [11:0] req_wdata,

    output logic        rsp_valid,
    output logic [11:0] rsp_rdata,
    output logic        write_done,
    output logic        busy,
    output logic        verify_err,

    output logic        mem_read_write,
    output logic        mem_write_commit,
    output logic [9:0]  mem_addr_data,
    input  logic [11:0] mem_result
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        W_ADDR = 3'd2,
        W_LO   = 3'd3,
        W_HI   = 3'd4
`ifdef MEM_SEQ_WRITE_VERIFY_EN
        ,
        W_VFY  = 3'd5
`endif
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [9:0]  addr_q;
    logic [11:0] data_q;

    logic        accept;
    logic        rd_capture;
    logic        wr_finish;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
    logic        vfy_check;
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Next-state logic. It also flags the cycles that capture read data,
    // finish a write, or check the readback.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        rd_capture = 1'b0;
        wr_finish  = 1'b0;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
        vfy_check  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = req_write ? W_ADDR : RD;
                end
            end
            RD: begin
                rd_capture = 1'b1;
                state_next = IDLE;
            end
            W_ADDR: begin
                state_next = W_LO;
            end
            W_LO: begin
                state_next = W_HI;
            end
            W_HI: begin
`ifdef MEM_SEQ_WRITE_VERIFY_EN
                state_next = W_VFY;
`else
                wr_finish  = 1'b1;
                state_next = IDLE;
`endif
            end
`ifdef MEM_SEQ_WRITE_VERIFY_EN
            W_VFY: begin
                vfy_check  = 1'b1;
                wr_finish  = 1'b1;
                state_next = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the accepted request so the bus never sees req_* directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= 10'd0;
            data_q <= 12'd0;
        end else if (accept) begin
            addr_q <= req_addr;
            data_q <= req_wdata;
        end
    end

    // Bus decode from the state register and latched request. While reset is
    // held, the bus shows the IDLE encoding, so an aborted write cannot commit
    // its remaining half.
    always_comb begin
        mem_read_write   = 1'b1;
        mem_write_commit = 1'b0;
        mem_addr_data    = 10'd0;
        if (rst_n) begin
            case (state)
                RD: begin
                    mem_addr_data = addr_q;
                end
                W_ADDR: begin
                    mem_read_write = 1'b0;
                    mem_addr_data  = addr_q;
                end
                W_LO: begin
                    mem_read_write   = 1'b0;
                    mem_write_commit = 1'b1;
                    mem_addr_data    = {3'b000, 1'b0, data_q[5:0]};
                end
                W_HI: begin
                    mem_read_write   = 1'b0;
                    mem_write_commit = 1'b1;
                    mem_addr_data    = {3'b000, 1'b1, data_q[11:6]};
                end
`ifdef MEM_SEQ_WRITE_VERIFY_EN
                W_VFY: begin
                    mem_addr_data = addr_q;
                end
`endif
                default: begin
                    mem_addr_data = 10'd0;
                end
            endcase
        end
    end

    // Read response: one-cycle valid pulse. The data holds until the next read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 12'd0;
        end else begin
            rsp_valid <= rd_capture;
            if (rd_capture) begin
                rsp_rdata <= mem_result;
            end
        end
    end

    // Write completion pulse, raised as the FSM returns to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_done <= 1'b0;
        end else begin
            write_done <= wr_finish;
        end
    end

`ifdef MEM_SEQ_WRITE_VERIFY_EN
    // Sticky readback mismatch flag. Only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            verify_err <= 1'b0;
        end else if (vfy_check && (mem_result != data_q)) begin
            verify_err <= 1'b1;
        end
    end
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer
// Drives mem_access_sequencer against a stand-in for the 1024x12 memory. It
// checks responses against a word-level reference array. Directed cases are
// followed by randomized traffic. Build with MEM_SEQ_WRITE_VERIFY_EN defined to
// exercise the readback feature.
`timescale 1ns/1ps
module tb_mem_access_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_addr;
    logic [11:0] req_wdata;
    logic        rsp_valid;
    logic [11:0] rsp_rdata;
    logic        write_done;
    logic        busy;
    logic        verify_err;
    logic        mem_read_write;
    logic        mem_write_commit;
    logic [9:0]  mem_addr_data;
    logic [11:0] mem_result;

    int total_count = 0;
    int bad_count   = 0;

`ifdef MEM_SEQ_WRITE_VERIFY_EN
    localparam int WR_LAT = 5;
`else
    localparam int WR_LAT = 4;
`endif

    // Memory stand-in: bus-level behaviour of the downstream block.
    logic [11:0] mem_array [0:1023];
    logic [9:0]  mem_wr_addr;
    logic        force_result;

    // Word-level reference model and bench-tracked expectations.
    logic [11:0] ref_mem [0:1023];
    logic [11:0] last_read;
    logic        exp_verify_err;
    logic [11:0] trace_bus [0:2];
    logic [9:0]  addr_pool [0:7];

    mem_access_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .write_done       (write_done),
        .busy             (busy),
        .verify_err       (verify_err),
        .mem_read_write   (mem_read_write),
        .mem_write_commit (mem_write_commit),
        .mem_addr_data    (mem_addr_data),
        .mem_result       (mem_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_result = force_result ? 12'h001 : mem_array[mem_addr_data];

    // Memory stand-in: address latch on (0,0) and half commit on (0,1).
    always @(posedge clk) begin
        if (mem_read_write === 1'b0) begin
            if (mem_write_commit === 1'b0) begin
                mem_wr_addr <= mem_addr_data;
            end else if (mem_addr_data[6]) begin
                mem_array[mem_wr_addr][11:6] = mem_addr_data[5:0];
            end else begin
                mem_array[mem_wr_addr][5:0] = mem_addr_data[5:0];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Response pulses never overlap.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checkOutput("pulse_exclusive", 32'(rsp_valid & write_done), 32'd0);
        end
    end

    // Present a request and return in the cycle after it was accepted.
    task automatic applyStimulus(input logic wr, input logic [9:0] addr, input logic [11:0] data);
        int wait_cycles = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        while (req_ready !== 1'b1 && wait_cycles < 20) begin
            @(posedge clk); #1;
            wait_cycles++;
        end
        if (req_ready !== 1'b1) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 10'($urandom);
        req_wdata = 12'($urandom);
    endtask

    task automatic doWrite(input logic [9:0] addr, input logic [11:0] data, input logic corrupt);
        int lat = 1;
        for (int i = 0; i < 3; i++) trace_bus[i] = 12'hFFF;
        applyStimulus(1'b1, addr, data);
        ref_mem[addr] = data;
        if (corrupt) exp_verify_err = 1'b1;
        while (write_done !== 1'b1 && lat < 12) begin
            if (lat <= 3) trace_bus[lat-1] = {mem_read_write, mem_write_commit, mem_addr_data};
            force_result = corrupt && (lat == 4);
            @(posedge clk); #1;
            lat++;
        end
        force_result = 1'b0;
        checkOutput("write_latency", 32'(lat), 32'(WR_LAT));
        checkOutput("bus_w_addr", 32'(trace_bus[0]), 32'({2'b00, addr}));
        checkOutput("bus_w_lo",   32'(trace_bus[1]), 32'({2'b01, 4'b0000, data[5:0]}));
        checkOutput("bus_w_hi",   32'(trace_bus[2]), 32'({2'b01, 4'b0001, data[11:6]}));
        checkOutput("verify_err", 32'(verify_err), 32'(exp_verify_err));
        checkOutput("rdata_hold", 32'(rsp_rdata), 32'(last_read));
    endtask

    task automatic doRead(input logic [9:0] addr, output logic [11:0] rdata);
        int lat = 1;
        applyStimulus(1'b0, addr, 12'($urandom));
        checkOutput("bus_rd", 32'({mem_read_write, mem_write_commit, mem_addr_data}), 32'({2'b10, addr}));
        while (rsp_valid !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("read_latency", 32'(lat), 32'd2);
        checkOutput("read_data", 32'(rsp_rdata), 32'(ref_mem[addr]));
        last_read = ref_mem[addr];
        rdata = rsp_rdata;
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        last_read      = 12'h000;
        exp_verify_err = 1'b0;
        checkOutput("rst_req_ready",  32'(req_ready), 32'd1);
        checkOutput("rst_busy",       32'(busy), 32'd0);
        checkOutput("rst_rsp_rdata",  32'(rsp_rdata), 32'd0);
        checkOutput("rst_rsp_valid",  32'(rsp_valid), 32'd0);
        checkOutput("rst_write_done", 32'(write_done), 32'd0);
        checkOutput("rst_verify_err", 32'(verify_err), 32'd0);
        checkOutput("rst_bus", 32'({mem_read_write, mem_write_commit, mem_addr_data}), 32'h800);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] rd;
        int stall;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 10'd0;
        req_wdata    = 12'd0;
        force_result = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem_array[i] = 12'h000;
            ref_mem[i]   = 12'h000;
        end
        addr_pool[0] = 10'd0;
        addr_pool[1] = 10'd1;
        addr_pool[2] = 10'h155;
        addr_pool[3] = 10'h2AA;
        addr_pool[4] = 10'h200;
        addr_pool[5] = 10'h3FE;
        addr_pool[6] = 10'd1023;
        addr_pool[7] = 10'h02F;

        $display("[TB] reset");
        doReset();

        $display("[TB] write then read 0x2F");
        doWrite(10'h02F, 12'h5A3, 1'b0);
        checkOutput("ex_bus_addr", 32'(trace_bus[0][9:0]), 32'h02F);
        checkOutput("ex_bus_lo",   32'(trace_bus[1][9:0]), 32'h023);
        checkOutput("ex_bus_hi",   32'(trace_bus[2][9:0]), 32'h056);
        doRead(10'h02F, rd);
        checkOutput("ex_read_5a3", 32'(rd), 32'h5A3);

        $display("[TB] address extremes");
        doWrite(10'd1023, 12'hFFF, 1'b0);
        doWrite(10'd0, 12'h000, 1'b0);
        doRead(10'd1023, rd);
        checkOutput("ex_read_1023", 32'(rd), 32'hFFF);
        doRead(10'd0, rd);
        checkOutput("ex_read_0", 32'(rd), 32'h000);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 10'h100, 12'h321);
        ref_mem[10'h100] = 12'h321;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 10'h101;
        req_wdata = 12'h654;
        stall = 0;
        while (req_ready !== 1'b1 && stall < 12) begin
            @(posedge clk); #1;
            stall++;
        end
        checkOutput("bp_stall_cycles", 32'(stall), 32'(WR_LAT - 1));
        checkOutput("bp_accept_in_done", 32'(write_done), 32'd1);
        doWrite(10'h101, 12'h654, 1'b0);
        doRead(10'h100, rd);
        doRead(10'h101, rd);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 80; n++) begin
            logic [9:0] a;
            a = addr_pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1) begin
                doWrite(a, 12'($urandom), 1'b0);
            end else begin
                doRead(a, rd);
            end
            repeat ($urandom_range(0, 2)) begin
                req_write = 1'($urandom);
                req_addr  = 10'($urandom);
                req_wdata = 12'($urandom);
                @(posedge clk); #1;
            end
        end

        $display("[TB] reset during high-half commit");
        doWrite(10'd5, 12'h000, 1'b0);
        applyStimulus(1'b1, 10'd5, 12'hABC);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abort_in_w_hi", 32'({mem_read_write, mem_write_commit, mem_addr_data}), 32'h46A);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_no_done", 32'(write_done), 32'd0);
        checkOutput("abort_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_read      = 12'h000;
        exp_verify_err = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_no_done_after", 32'(write_done), 32'd0);
        checkOutput("abort_ready", 32'(req_ready), 32'd1);
        ref_mem[5] = {ref_mem[5][11:6], 6'h3C};
        doRead(10'd5, rd);
        checkOutput("abort_read_low_only", 32'(rd), 32'h03C);

`ifdef MEM_SEQ_WRITE_VERIFY_EN
        $display("[TB] readback verify");
        doWrite(10'h0AA, 12'h000, 1'b1);
        checkOutput("verify_rise", 32'(verify_err), 32'd1);
        doWrite(10'h0AB, 12'h777, 1'b0);
        doWrite(10'h0AC, 12'h888, 1'b0);
        checkOutput("verify_sticky", 32'(verify_err), 32'd1);
        doRead(10'h0AA, rd);
        doReset();
        checkOutput("verify_cleared", 32'(verify_err), 32'd0);
`else
        doWrite(10'h0AA, 12'h000, 1'b0);
        checkOutput("verify_tied_low", 32'(verify_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Request-level front end for the 1024×12 `memory` block. It accepts single-word read and write requests over a valid/ready handshake and converts each one into the memory's native bus sequence:
- reads take one bus cycle;
- writes take three bus cycles (address latch, low-half commit, high-half commit).

It sits directly upstream of `memory` and owns its `read_write`, `write_commit` and `addr_data` inputs. It also consumes `mem_result`.

## Interface
Parameters: none (geometry fixed at 10-bit address, 12-bit word, 6-bit half).

- `clk` in 1 — single clock for all logic.
- `rst_n` in 1 — synchronous, active-low reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — sequencer can accept; a transfer occurs when `req_valid & req_ready` at a posedge.
- `req_write` in 1 — 1 = write, 0 = read.
- `req_addr` in 10 — word address.
- `req_wdata` in 12 — write data; ignored for reads.
- `rsp_valid` out 1 — one-cycle pulse; `rsp_rdata` is valid.
- `rsp_rdata` out 12 — read data; holds its value until the next read response.
- `write_done` out 1 — one-cycle pulse; the write sequence is complete.
- `busy` out 1 — high in any state other than IDLE.
- `verify_err` out 1 — sticky readback mismatch flag (see Configuration).
- `mem_read_write` out 1 — drives `memory.read_write`.
- `mem_write_commit` out 1 — drives `memory.write_commit`.
- `mem_addr_data` out 10 — drives `memory.addr_data`.
- `mem_result` in 12 — from `memory.mem_result` (combinational read data).

## Operation
- The FSM has states IDLE, RD, W_ADDR, W_LO, W_HI and W_VFY. W_VFY exists only with the macro.
- `req_ready = (state == IDLE)`. Accepting a request latches `req_addr` and `req_wdata` into `addr_q` and `data_q`.
- Bus outputs decode only from the state register and the latched request. There is no combinational path from `req_*` to `mem_*`.

Bus encoding per state (`read_write`, `write_commit`, `addr_data`):
- IDLE: 1, 0, 0 — a harmless read of address 0.
- RD: 1, 0, `addr_q`.
- W_ADDR: 0, 0, `addr_q` — memory latches the write address.
- W_LO: 0, 1, {3'b000, 1'b0, `data_q[5:0]`}.
- W_HI: 0, 1, {3'b000, 1'b1, `data_q[11:6]`}.
- W_VFY: 1, 0, `addr_q`.

State transitions:
- IDLE → RD on an accepted read; IDLE → W_ADDR on an accepted write.
- RD → IDLE. `mem_result` is captured into `rsp_rdata` at the end of RD, with `rsp_valid` asserted.
- W_ADDR → W_LO → W_HI.
- W_HI → IDLE, asserting `write_done`. With the macro, W_HI → W_VFY instead.
- W_VFY → IDLE, asserting `write_done`. If `mem_result != data_q`, `verify_err` is set.
- `busy = (state != IDLE)`.

Reset (`rst_n` low at a posedge) forces:
- state = IDLE;
- `rsp_valid`, `write_done` and `verify_err` = 0;
- `rsp_rdata` = 0;
- bus outputs to the IDLE encoding.

Boundary conditions:
- Reset mid-write aborts immediately. A partially committed word (low half new, high half old) is permitted and not reported.
- A request presented while busy is held off by `req_ready = 0`. Inputs may change freely while `req_valid` is low.
- Back-to-back requests are accepted in the same cycle as the previous `rsp_valid` or `write_done` pulse, since the FSM is back in IDLE.
- A write followed by a read of the same address returns the new data, because both commits land before IDLE.
- Address 1023 and address 0 receive no special handling.

## Timing
- Read accepted at edge N: RD drives the bus during cycle N+1. `rsp_valid` and `rsp_rdata` are visible in cycle N+2. Latency is 2; throughput is 1 read per 2 cycles.
- Write accepted at edge N: W_ADDR in N+1, W_LO in N+2, W_HI in N+3. Both halves are in the array after edge N+3. `write_done` fires in N+4, or N+5 with verify. Throughput is 1 write per 4 cycles (5 with verify).
- `rsp_valid` and `write_done` are never high in the same cycle.

## Configuration
- Macro `MEM_SEQ_WRITE_VERIFY_EN`.
- When defined: the W_VFY state is built. Each write is read back one cycle after W_HI and compared against `data_q`. A mismatch sets `verify_err`, which stays set until reset.
- When undefined: there is no W_VFY state, W_HI goes directly to IDLE, and `verify_err` is tied to 0.

## Test plan
- Reset: hold `rst_n` low for 2 cycles, then release. Required: `req_ready=1`, `busy=0`, `rsp_rdata=0`, bus outputs = (1, 0, 0).
- Write then read: write 0x5A3 to addr 0x2F, then read 0x2F. Bus shows `addr_data` 0x02F, then 0x023, then 0x056. Read returns `rsp_rdata=0xA5C`?
  - No: the required `rsp_rdata` is 0x5A3, arriving 2 cycles after the read is accepted.
- Backpressure: hold `req_valid` with a new write during an active write. Required: `req_ready=0` for exactly 3 cycles (4 with verify); the request is accepted in the `write_done` cycle.
- Extremes: write 0xFFF to addr 1023 and 0x000 to addr 0, then read both. Required: reads return 0xFFF and 0x000 respectively.
- Reset mid-operation: assert `rst_n` low during W_HI of a 0xABC write to addr 5, previously 0x000. Required: no `write_done` pulse, FSM returns to IDLE, and a subsequent read returns 0x03C (low half only).
- Verify (macro defined): force `mem_result` to 0x001 during W_VFY of a 0x000 write. Required: `verify_err` rises with `write_done` and stays high across later good writes until reset.
